// File: rtl/fll_cfg_responder.sv
// rtl/fll_cfg_responder.sv - FLL configuration responder behind an asynchronous 4-phase req/ack handshake
//
// Ports
//   HCLK        clock, rising edge
//   HRESETn     asynchronous active-low reset
//   fll_req     initiator request, asynchronous to HCLK (4-phase level handshake)
//   fll_wrn     1 = read, 0 = write; stable while fll_req=1
//   fll_add     register index (0 STATUS, 1 CFG1, 2 CFG2, 3 INTEG)
//   fll_data    write data
//   fll_ack     acknowledge, straight from a flop
//   fll_r_data  read data, straight from a flop; holds until the next read
//   status_i    live FLL status, synchronous to HCLK
//   cfg1_o      CFG1 register contents
//   cfg2_o      CFG2 register contents
//   integ_o     INTEG register contents
//   cfg_upd_o   one-hot, one-cycle pulse naming the register index just written

module fll_cfg_responder #(
    parameter logic [31:0] CFG1_RST  = 32'h0000_0000,
    parameter logic [31:0] CFG2_RST  = 32'h0000_0000,
    parameter logic [31:0] INTEG_RST = 32'h0000_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        fll_req,
    input  logic        fll_wrn,
    input  logic [1:0]  fll_add,
    input  logic [31:0] fll_data,
    output logic        fll_ack,
    output logic [31:0] fll_r_data,
    input  logic [15:0] status_i,
    output logic [31:0] cfg1_o,
    output logic [31:0] cfg2_o,
    output logic [31:0] integ_o,
    output logic [3:0]  cfg_upd_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Two-flop synchronizer; only req_s_q may steer control logic.
    logic        req_s0_q;
    logic        req_s_q;

    // Access captured in IDLE; the live bus is never looked at afterwards.
    logic        wrn_q,  wrn_d;
    logic [1:0]  add_q,  add_d;
    logic [31:0] data_q, data_d;

    logic        ack_q,    ack_d;
    logic [31:0] r_data_q, r_data_d;
    logic [31:0] cfg1_q,   cfg1_d;
    logic [31:0] cfg2_q,   cfg2_d;
    logic [31:0] integ_q,  integ_d;
    logic [3:0]  upd_q,    upd_d;

    logic [31:0] rd_mux;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            req_s0_q <= 1'b0;
            req_s_q  <= 1'b0;
        end else begin
            req_s0_q <= fll_req;
            req_s_q  <= req_s0_q;
        end
    end

    // Read multiplexer over the captured index; STATUS is sampled live.
    always_comb begin
        rd_mux = 32'h0;
        case (add_q)
            2'd0:    rd_mux = {16'h0, status_i};
            2'd1:    rd_mux = cfg1_q;
            2'd2:    rd_mux = cfg2_q;
            default: rd_mux = integ_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        wrn_d    = wrn_q;
        add_d    = add_q;
        data_d   = data_q;
        r_data_d = r_data_q;
        cfg1_d   = cfg1_q;
        cfg2_d   = cfg2_q;
        integ_d  = integ_q;
        upd_d    = 4'b0000;

        case (state_q)
            IDLE: begin
                if (req_s_q) begin
                    wrn_d   = fll_wrn;
                    add_d   = fll_add;
                    data_d  = fll_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // The access always completes, even if fll_req has already
                // dropped; the handshake then finishes through ACK.
                state_d = ACK;
                if (wrn_q) begin
                    r_data_d = rd_mux;
                end else begin
                    case (add_q)
                        2'd1: begin
                            cfg1_d   = data_q;
                            upd_d[1] = 1'b1;
                        end
                        2'd2: begin
                            cfg2_d   = data_q;
                            upd_d[2] = 1'b1;
                        end
                        2'd3: begin
                            integ_d  = data_q;
                            upd_d[3] = 1'b1;
                        end
                        default: begin
                            // STATUS is read-only: write is dropped, no pulse.
                        end
                    endcase
                end
            end
            ACK: begin
                if (!req_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered copy of (state == ACK) so fll_ack comes from a flop.
        ack_d = (state_d == ACK);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            wrn_q    <= 1'b0;
            add_q    <= 2'd0;
            data_q   <= 32'h0;
            ack_q    <= 1'b0;
            r_data_q <= 32'h0;
            cfg1_q   <= CFG1_RST;
            cfg2_q   <= CFG2_RST;
            integ_q  <= INTEG_RST;
            upd_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            wrn_q    <= wrn_d;
            add_q    <= add_d;
            data_q   <= data_d;
            ack_q    <= ack_d;
            r_data_q <= r_data_d;
            cfg1_q   <= cfg1_d;
            cfg2_q   <= cfg2_d;
            integ_q  <= integ_d;
            upd_q    <= upd_d;
        end
    end

    assign fll_ack    = ack_q;
    assign fll_r_data = r_data_q;
    assign cfg1_o     = cfg1_q;
    assign cfg2_o     = cfg2_q;
    assign integ_o    = integ_q;
    assign cfg_upd_o  = upd_q;

endmodule

// File: tb/tb_fll_cfg_responder.sv
// tb/tb_fll_cfg_responder.sv - table-driven self-checking bench for fll_cfg_responder

module tb_fll_cfg_responder;

    localparam logic [31:0] C1R = 32'h1111_0001;
    localparam logic [31:0] C2R = 32'h2222_0002;
    localparam logic [31:0] IR  = 32'h3333_0003;

    logic        HCLK;
    logic        HRESETn;
    logic        fll_req;
    logic        fll_wrn;
    logic [1:0]  fll_add;
    logic [31:0] fll_data;
    logic        fll_ack;
    logic [31:0] fll_r_data;
    logic [15:0] status_i;
    logic [31:0] cfg1_o;
    logic [31:0] cfg2_o;
    logic [31:0] integ_o;
    logic [3:0]  cfg_upd_o;

    int checks = 0;
    int errors = 0;

    fll_cfg_responder #(
        .CFG1_RST (C1R),
        .CFG2_RST (C2R),
        .INTEG_RST(IR)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .fll_req   (fll_req),
        .fll_wrn   (fll_wrn),
        .fll_add   (fll_add),
        .fll_data  (fll_data),
        .fll_ack   (fll_ack),
        .fll_r_data(fll_r_data),
        .status_i  (status_i),
        .cfg1_o    (cfg1_o),
        .cfg2_o    (cfg2_o),
        .integ_o   (integ_o),
        .cfg_upd_o (cfg_upd_o)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        wrn;
        logic [1:0]  add;
        logic [31:0] data;
        logic [15:0] status;
        logic [31:0] exp_r;
        logic [31:0] exp_cfg1;
        logic [31:0] exp_cfg2;
        logic [31:0] exp_integ;
        logic [3:0]  exp_upd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Full 4-phase handshake. Edges are counted from the first rising edge
    // after fll_req goes high (that edge is 1). The bus is scrambled while the
    // access is in EXEC to show only the captured values are used.
    task automatic access(input logic wrn, input logic [1:0] add, input logic [31:0] data,
                          output int lat, output int rel, output logic [31:0] r_at_ack,
                          output logic [3:0] upd_seen, output int upd_cnt);
        @(negedge HCLK);
        fll_wrn  = wrn;
        fll_add  = add;
        fll_data = data;
        fll_req  = 1'b1;
        lat = 0; rel = 0; upd_seen = 4'b0; upd_cnt = 0; r_at_ack = 32'hx;
        while (!fll_ack && lat < 20) begin
            @(posedge HCLK); #1;
            lat++;
            if (cfg_upd_o != 4'b0) begin upd_seen |= cfg_upd_o; upd_cnt++; end
            if (lat == 3) begin
                fll_add  = ~add;
                fll_data = ~data;
                fll_wrn  = wrn;
            end
        end
        r_at_ack = fll_r_data;
        for (int i = 0; i < 2; i++) begin
            @(posedge HCLK); #1;
            if (cfg_upd_o != 4'b0) begin upd_seen |= cfg_upd_o; upd_cnt++; end
        end
        @(negedge HCLK);
        fll_req = 1'b0;
        while (fll_ack && rel < 20) begin
            @(posedge HCLK); #1;
            rel++;
            if (cfg_upd_o != 4'b0) begin upd_seen |= cfg_upd_o; upd_cnt++; end
        end
        repeat (2) begin
            @(posedge HCLK); #1;
            if (cfg_upd_o != 4'b0) begin upd_seen |= cfg_upd_o; upd_cnt++; end
        end
    endtask

    initial begin
        int          lat, rel, upd_cnt, ack_cnt, first_ack;
        logic [31:0] r_at_ack;
        logic [3:0]  upd_seen;

        vecs[0]  = '{1'b0, 2'd2, 32'hDEAD_BEEF, 16'h0000, 32'h0000_0000, C1R,          32'hDEAD_BEEF, IR,            4'b0100};
        vecs[1]  = '{1'b1, 2'd2, 32'h0000_0000, 16'h0000, 32'hDEAD_BEEF, C1R,          32'hDEAD_BEEF, IR,            4'b0000};
        vecs[2]  = '{1'b1, 2'd0, 32'h0000_0000, 16'h8001, 32'h0000_8001, C1R,          32'hDEAD_BEEF, IR,            4'b0000};
        vecs[3]  = '{1'b0, 2'd0, 32'hFFFF_FFFF, 16'h8001, 32'h0000_8001, C1R,          32'hDEAD_BEEF, IR,            4'b0000};
        vecs[4]  = '{1'b0, 2'd3, 32'hA5A5_0001, 16'h0000, 32'h0000_8001, C1R,          32'hDEAD_BEEF, 32'hA5A5_0001, 4'b1000};
        vecs[5]  = '{1'b0, 2'd1, 32'h0BAD_F00D, 16'h0000, 32'h0000_8001, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'hA5A5_0001, 4'b0010};
        vecs[6]  = '{1'b0, 2'd3, 32'h1234_5678, 16'h0000, 32'h0000_8001, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h1234_5678, 4'b1000};
        vecs[7]  = '{1'b0, 2'd1, 32'hCAFE_0042, 16'h0000, 32'h0000_8001, 32'hCAFE_0042, 32'hDEAD_BEEF, 32'h1234_5678, 4'b0010};
        vecs[8]  = '{1'b1, 2'd3, 32'h0000_0000, 16'h0000, 32'h1234_5678, 32'hCAFE_0042, 32'hDEAD_BEEF, 32'h1234_5678, 4'b0000};
        vecs[9]  = '{1'b1, 2'd1, 32'h0000_0000, 16'h0000, 32'hCAFE_0042, 32'hCAFE_0042, 32'hDEAD_BEEF, 32'h1234_5678, 4'b0000};
        vecs[10] = '{1'b1, 2'd0, 32'h0000_0000, 16'h7FFE, 32'h0000_7FFE, 32'hCAFE_0042, 32'hDEAD_BEEF, 32'h1234_5678, 4'b0000};

        HRESETn  = 1'b0;
        fll_req  = 1'b0;
        fll_wrn  = 1'b0;
        fll_add  = 2'd0;
        fll_data = 32'h0;
        status_i = 16'h0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_ack",    {31'b0, fll_ack}, 32'h0);
        chk("reset_rdata",  fll_r_data, 32'h0);
        chk("reset_upd",    {28'b0, cfg_upd_o}, 32'h0);
        chk("reset_cfg1",   cfg1_o, C1R);
        chk("reset_cfg2",   cfg2_o, C2R);
        chk("reset_integ",  integ_o, IR);
        @(negedge HCLK);
        HRESETn = 1'b1;

        for (int v = 0; v < 11; v++) begin
            status_i = vecs[v].status;
            access(vecs[v].wrn, vecs[v].add, vecs[v].data, lat, rel, r_at_ack, upd_seen, upd_cnt);
            chk($sformatf("v%0d_ack_latency", v), lat, 4);
            chk($sformatf("v%0d_release_latency", v), rel, 3);
            chk($sformatf("v%0d_rdata_at_ack", v), r_at_ack, vecs[v].exp_r);
            chk($sformatf("v%0d_rdata_held", v), fll_r_data, vecs[v].exp_r);
            chk($sformatf("v%0d_cfg1", v), cfg1_o, vecs[v].exp_cfg1);
            chk($sformatf("v%0d_cfg2", v), cfg2_o, vecs[v].exp_cfg2);
            chk($sformatf("v%0d_integ", v), integ_o, vecs[v].exp_integ);
            chk($sformatf("v%0d_upd_mask", v), {28'b0, upd_seen}, {28'b0, vecs[v].exp_upd});
            chk($sformatf("v%0d_upd_pulses", v), upd_cnt, (vecs[v].exp_upd != 4'b0) ? 1 : 0);
        end

        // Short request: fll_req high for a single cycle.
        @(negedge HCLK);
        fll_wrn  = 1'b0;
        fll_add  = 2'd2;
        fll_data = 32'h5555_AAAA;
        fll_req  = 1'b1;
        @(negedge HCLK);
        fll_req  = 1'b0;
        ack_cnt = 0; first_ack = 0; upd_cnt = 0;
        for (int e = 2; e <= 14; e++) begin
            @(posedge HCLK); #1;
            if (fll_ack) begin
                ack_cnt++;
                if (first_ack == 0) first_ack = e;
            end
            if (cfg_upd_o != 4'b0) upd_cnt++;
        end
        chk("short_ack_cycles", ack_cnt, 1);
        chk("short_ack_edge", first_ack, 4);
        chk("short_upd_pulses", upd_cnt, 1);
        chk("short_cfg2", cfg2_o, 32'h5555_AAAA);
        chk("short_idle_ack", {31'b0, fll_ack}, 32'h0);

        // Reset asserted while in ACK, fll_req held high throughout.
        @(negedge HCLK);
        fll_wrn  = 1'b0;
        fll_add  = 2'd1;
        fll_data = 32'h7777_0007;
        fll_req  = 1'b1;
        lat = 0;
        while (!fll_ack && lat < 20) begin
            @(posedge HCLK); #1;
            lat++;
        end
        chk("rst_pre_ack_latency", lat, 4);
        chk("rst_pre_cfg1", cfg1_o, 32'h7777_0007);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("rst_ack_dropped", {31'b0, fll_ack}, 32'h0);
        chk("rst_cfg1", cfg1_o, C1R);
        chk("rst_cfg2", cfg2_o, C2R);
        chk("rst_integ", integ_o, IR);
        chk("rst_rdata", fll_r_data, 32'h0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        lat = 0;
        while (!fll_ack && lat < 20) begin
            @(posedge HCLK); #1;
            lat++;
        end
        chk("rst_new_ack_latency", lat, 4);
        chk("rst_new_cfg1", cfg1_o, 32'h7777_0007);
        @(negedge HCLK);
        fll_req = 1'b0;
        rel = 0;
        while (fll_ack && rel < 20) begin
            @(posedge HCLK); #1;
            rel++;
        end
        chk("rst_new_release", rel, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fll_cfg_responder.md
FLL_CFG_RESPONDER -- requirements
Module: fll_cfg_responder

Interface
REQ-001 Parameter CFG1_RST, default 32'h0000_0000, reset value of the CFG1 register.
REQ-002 Parameter CFG2_RST, default 32'h0000_0000, reset value of the CFG2 register.
REQ-003 Parameter INTEG_RST, default 32'h0000_0000, reset value of the INTEG register.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset: HCLK input 1 (rising edge); HRESETn input 1 (async active-low).
REQ-005 fll_req input 1: request from the initiator, asynchronous to HCLK; 4-phase level handshake.
REQ-006 fll_wrn input 1: 1 = read, 0 = write; stable while fll_req=1.
REQ-007 fll_add input 2: register index; stable while fll_req=1.
REQ-008 fll_data input 32: write data; stable while fll_req=1.
REQ-009 fll_ack output 1: acknowledge, driven directly from a flop.
REQ-010 fll_r_data output 32: read data, driven directly from a flop.
REQ-011 status_i input 16: live FLL status, synchronous to HCLK.
REQ-012 cfg1_o, cfg2_o, integ_o outputs 32 each: current register contents.
REQ-013 cfg_upd_o output 4: one-hot one-cycle pulse indicating which register index was written.

Function
REQ-014 fll_req SHALL pass through a 2-flop synchronizer (req_s0 -> req_s); only req_s drives control logic.
REQ-015 The FSM SHALL have three states: IDLE, EXEC, ACK.
REQ-016 IDLE: if req_s=1, capture fll_wrn, fll_add and fll_data into internal flops and go to EXEC; otherwise stay in IDLE.
REQ-017 EXEC: perform the captured access (REQ-019..REQ-022) and go to ACK unconditionally. The state lasts exactly one cycle.
REQ-018 ACK: fll_ack=1; stay while req_s=1; go to IDLE when req_s=0.
REQ-019 fll_ack SHALL be the registered flag (state==ACK), so it rises on the EXEC->ACK edge and falls on the ACK->IDLE edge.
REQ-020 Register map by index:
  - 0 STATUS: read-only, reads {16'h0, status_i} sampled in EXEC.
  - 1 CFG1.
  - 2 CFG2.
  - 3 INTEG.
REQ-021 A write in EXEC SHALL update the indexed register on the EXEC->ACK edge and set cfg_upd_o[index]=1 for exactly that one following cycle. A write to index 0 SHALL change nothing, and cfg_upd_o SHALL stay 0.
REQ-022 A read in EXEC SHALL load fll_r_data on the EXEC->ACK edge. fll_r_data is therefore valid no later than fll_ack rising, and SHALL hold until the next read's EXEC. A write SHALL leave fll_r_data unchanged.
REQ-023 Latency: fll_req rising before HCLK edge n gives req_s=1 after edge n+1, EXEC after edge n+2, and fll_ack=1 after edge n+3. Release: fll_req falling before edge m gives fll_ack=0 after edge m+2.
REQ-024 fll_req dropping during EXEC SHALL NOT abort the access: the FSM still passes through ACK, then leaves to IDLE on the first cycle req_s=0.
REQ-025 A new request SHALL be accepted only from IDLE. fll_req staying high after fll_ack falls cannot occur in protocol; if it does, the request SHALL be treated as a new access.
REQ-026 Captured address and data SHALL be used for the access; fll_add and fll_data SHALL NOT be sampled outside IDLE.

Reset
REQ-027 Asynchronous reset SHALL set:
  - state=IDLE; req_s0, req_s, fll_ack to 0.
  - fll_r_data=0 and cfg_upd_o=0.
  - CFG1=CFG1_RST, CFG2=CFG2_RST, INTEG=INTEG_RST.
REQ-028 Reset mid-handshake SHALL immediately drop fll_ack and restore register reset values. After release, a still-high fll_req SHALL be served as a new access.

Verification
REQ-029 Write: fll_wrn=0, fll_add=2, fll_data=32'hDEAD_BEEF, raise fll_req. Required: fll_ack rises 3 edges later; cfg2_o=32'hDEAD_BEEF; cfg_upd_o=4'b0100 for one cycle; fll_ack drops 2 edges after fll_req falls.
REQ-030 Read back: fll_wrn=1, fll_add=2. Required: fll_r_data=32'hDEAD_BEEF on or before the fll_ack rise, held until the next read.
REQ-031 Status read with status_i=16'h8001, fll_add=0, read. Required: fll_r_data=32'h0000_8001. Then a write of 32'hFFFF_FFFF to index 0: no register changes and cfg_upd_o=0.
REQ-032 Short request: fll_req high for 1 cycle only. Required: one ACK pulse; access completed; FSM back in IDLE.
REQ-033 Assert HRESETn=0 while in ACK. Required: fll_ack=0 immediately; cfg1_o=CFG1_RST. After release with fll_req still high, a new access completes.
REQ-034 Back-to-back: 4 writes to indices 3,1,3,1 with full 4-phase handshakes. Required: integ_o and cfg1_o hold the last written values; no extra cfg_upd_o pulses.
